dma_ctrl: RTL



---
 rtl/dma_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_ctrl.sv
// dma_ctrl: memory-to-memory DMA sequencing engine acting as an AXI master.
//
// Latches DMAEN/DMASRC/DMADST/DMALEN from the DMA register block, then copies
// the block as alternating INCR read bursts (into a local buffer) and write
// bursts (out of it). Bursts are clipped so they never cross a 4 KB boundary
// on either side. DMA_interrupt is raised on completion and held until DMAEN
// is cleared.
//
// Optional feature macro: DMA_ERR_CHECK_EN
//   defined   : non-OKAY RResp/BResp sets DMA_err and ends the transfer early.
//   undefined : responses are ignored and DMA_err is tied low.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   DMAEN                     start request (high) / interrupt clear (low)
//   DMASRC, DMADST, DMALEN    byte addresses (word aligned) and length in words
//   M_AR*, M_R*               AXI read address / read data channels
//   M_AW*, M_W*, M_B*         AXI write address / write data / response channels
//   DMA_interrupt             transfer complete
//   DMA_err                   response error seen during the transfer

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module dma_ctrl #(
   parameter int unsigned MAX_BURST = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       DMAEN,
   input  logic [31:0]                DMASRC,
   input  logic [31:0]                DMADST,
   input  logic [31:0]                DMALEN,
   // read address channel
   output logic [`AXI_ID_BITS-1:0]    M_ARID,
   output logic [`AXI_ADDR_BITS-1:0]  M_ARAddr,
   output logic [`AXI_LEN_BITS-1:0]   M_ARLen,
   output logic [`AXI_SIZE_BITS-1:0]  M_ARSize,
   output logic [1:0]                 M_ARBurst,
   output logic                       M_ARValid,
   input  logic                       M_ARReady,
   // read data channel
   input  logic [`AXI_DATA_BITS-1:0]  M_RData,
   input  logic [1:0]                 M_RResp,
   input  logic                       M_RLast,
   input  logic                       M_RValid,
   output logic                       M_RReady,
   // write address channel
   output logic [`AXI_ID_BITS-1:0]    M_AWID,
   output logic [`AXI_ADDR_BITS-1:0]  M_AWAddr,
   output logic [`AXI_LEN_BITS-1:0]   M_AWLen,
   output logic [`AXI_SIZE_BITS-1:0]  M_AWSize,
   output logic [1:0]                 M_AWBurst,
   output logic                       M_AWValid,
   input  logic                       M_AWReady,
   // write data channel
   output logic [`AXI_DATA_BITS-1:0]  M_WData,
   output logic [`AXI_STRB_BITS-1:0]  M_WStrb,
   output logic                       M_WLast,
   output logic                       M_WValid,
   input  logic                       M_WReady,
   // write response channel
   input  logic [1:0]                 M_BResp,
   input  logic                       M_BValid,
   output logic                       M_BReady,
   // status
   output logic                       DMA_interrupt,
   output logic                       DMA_err
);

   localparam int unsigned LEN_W = $clog2(MAX_BURST) + 1;
   localparam int unsigned IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   typedef enum logic [2:0] {
      IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE
   } state_t;

   state_t                     state;
   logic [31:0]                src_q;
   logic [31:0]                dst_q;
   logic [31:0]                rem_q;
   logic [LEN_W-1:0]           len_q;
   logic [LEN_W-1:0]           len_m1_q;
   logic [LEN_W-1:0]           cnt_q;
   logic                       ar_valid_q;
   logic                       r_ready_q;
   logic                       aw_valid_q;
   logic                       w_valid_q;
   logic                       w_last_q;
   logic [`AXI_DATA_BITS-1:0]  w_data_q;
   logic                       b_ready_q;
   logic                       irq_q;
   logic [`AXI_DATA_BITS-1:0]  buf_q [MAX_BURST];

   logic [LEN_W-1:0]           cnt_nxt;
   logic [31:0]                nxt_src;
   logic [31:0]                nxt_dst;
   logic [31:0]                nxt_rem;
   logic [LEN_W-1:0]           start_len;
   logic [LEN_W-1:0]           next_len;
   logic                       r_err_c;
   logic                       b_err_c;
   logic                       unused_in;

   // Beats for one burst: min(remaining, MAX_BURST, words left in either 4 KB page).
   function automatic logic [LEN_W-1:0] burst_len(input logic [31:0] s,
                                                  input logic [31:0] d,
                                                  input logic [31:0] r);
      logic [31:0] n;
      logic [31:0] s_room;
      logic [31:0] d_room;
      n      = 32'(MAX_BURST);
      s_room = 32'd1024 - 32'(s[11:2]);
      d_room = 32'd1024 - 32'(d[11:2]);
      if (s_room < n) n = s_room;
      if (d_room < n) n = d_room;
      if (r < n)      n = r;
      return LEN_W'(n);
   endfunction

   assign cnt_nxt   = cnt_q + LEN_W'(1);
   assign nxt_src   = src_q + (32'(len_q) << 2);
   assign nxt_dst   = dst_q + (32'(len_q) << 2);
   assign nxt_rem   = rem_q - 32'(len_q);
   assign start_len = burst_len(DMASRC, DMADST, DMALEN);
   assign next_len  = burst_len(nxt_src, nxt_dst, nxt_rem);

   // An R error anywhere in the burst (err_q already set, or this beat) aborts the write.
`ifdef DMA_ERR_CHECK_EN
   logic err_q;
   assign r_err_c   = err_q || (M_RResp != 2'b00);
   assign b_err_c   = (M_BResp != 2'b00);
   assign DMA_err   = err_q;
   assign unused_in = M_RLast;
`else
   assign r_err_c   = 1'b0;
   assign b_err_c   = 1'b0;
   assign DMA_err   = 1'b0;
   assign unused_in = ^{M_RLast, M_RResp, M_BResp};
`endif

   // Sequencer: state plus all registered channel controls.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         rem_q      <= '0;
         len_q      <= '0;
         len_m1_q   <= '0;
         cnt_q      <= '0;
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         w_last_q   <= 1'b0;
         w_data_q   <= '0;
         b_ready_q  <= 1'b0;
         irq_q      <= 1'b0;
`ifdef DMA_ERR_CHECK_EN
         err_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (DMAEN) begin
                  src_q <= {DMASRC[31:2], 2'b00};
                  dst_q <= {DMADST[31:2], 2'b00};
                  rem_q <= DMALEN;
                  if (DMALEN == 32'd0) begin
                     state <= DONE;
                     irq_q <= 1'b1;
                  end else begin
                     state      <= RADDR;
                     ar_valid_q <= 1'b1;
                     len_q      <= start_len;
                     len_m1_q   <= start_len - LEN_W'(1);
`ifdef DMA_ERR_CHECK_EN
                     err_q      <= 1'b0;
`endif
                  end
               end
            end

            RADDR: begin
               if (M_ARReady) begin
                  ar_valid_q <= 1'b0;
                  r_ready_q  <= 1'b1;
                  cnt_q      <= '0;
                  state      <= RDATA;
               end
            end

            // Beat count, not RLast, ends the burst.
            RDATA: begin
               if (M_RValid) begin
`ifdef DMA_ERR_CHECK_EN
                  if (M_RResp != 2'b00) err_q <= 1'b1;
`endif
                  if (cnt_q == len_m1_q) begin
                     cnt_q     <= '0;
                     r_ready_q <= 1'b0;
                     if (r_err_c) begin
                        state <= DONE;
                        irq_q <= 1'b1;
                     end else begin
                        state      <= WADDR;
                        aw_valid_q <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_nxt;
                  end
               end
            end

            // First write beat is preloaded here so WData is valid from cycle one.
            WADDR: begin
               if (M_AWReady) begin
                  aw_valid_q <= 1'b0;
                  w_valid_q  <= 1'b1;
                  w_data_q   <= buf_q[0];
                  w_last_q   <= (len_m1_q == '0);
                  cnt_q      <= '0;
                  state      <= WDATA;
               end
            end

            WDATA: begin
               if (M_WReady) begin
                  if (w_last_q) begin
                     w_valid_q <= 1'b0;
                     w_last_q  <= 1'b0;
                     b_ready_q <= 1'b1;
                     cnt_q     <= '0;
                     state     <= WRESP;
                  end else begin
                     cnt_q    <= cnt_nxt;
                     w_data_q <= buf_q[cnt_nxt[IDX_W-1:0]];
                     w_last_q <= (cnt_nxt == len_m1_q);
                  end
               end
            end

            WRESP: begin
               if (M_BValid) begin
                  b_ready_q <= 1'b0;
                  src_q     <= nxt_src;
                  dst_q     <= nxt_dst;
                  rem_q     <= nxt_rem;
                  if (b_err_c || (nxt_rem == 32'd0)) begin
`ifdef DMA_ERR_CHECK_EN
                     if (b_err_c) err_q <= 1'b1;
`endif
                     state <= DONE;
                     irq_q <= 1'b1;
                  end else begin
                     state      <= RADDR;
                     ar_valid_q <= 1'b1;
                     len_q      <= next_len;
                     len_m1_q   <= next_len - LEN_W'(1);
                  end
               end
            end

            DONE: begin
               if (!DMAEN) begin
                  irq_q <= 1'b0;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   // Burst buffer; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (state == RDATA && M_RValid)
         buf_q[cnt_q[IDX_W-1:0]] <= M_RData;
   end

   assign M_ARID        = '0;
   assign M_ARAddr      = `AXI_ADDR_BITS'(src_q);
   assign M_ARLen       = `AXI_LEN_BITS'(len_m1_q);
   assign M_ARSize      = `AXI_SIZE_BITS'(3'b010);
   assign M_ARBurst     = 2'b01;
   assign M_ARValid     = ar_valid_q;
   assign M_RReady      = r_ready_q;

   assign M_AWID        = '0;
   assign M_AWAddr      = `AXI_ADDR_BITS'(dst_q);
   assign M_AWLen       = `AXI_LEN_BITS'(len_m1_q);
   assign M_AWSize      = `AXI_SIZE_BITS'(3'b010);
   assign M_AWBurst     = 2'b01;
   assign M_AWValid     = aw_valid_q;

   assign M_WData       = w_data_q;
   assign M_WStrb       = '1;
   assign M_WLast       = w_last_q;
   assign M_WValid      = w_valid_q;
   assign M_BReady      = b_ready_q;

   assign DMA_interrupt = irq_q;

endmodule
